// File: rtl/mux_ctx_sequencer_pkg.sv
// Shared definitions for the context-sequenced select generator.
//   NUM_CTX_DEF / SEL_W_DEF : default context count and select width
//   CTX_IDX_W               : width of a context index (cfg_addr, ctx_idx, ctx_last)
//   state_e                 : sequencer state encoding (IDLE=0, RUN=1)
//   ctx_inc                 : next sequential context index
package mux_ctx_sequencer_pkg;

  localparam int NUM_CTX_DEF = 8;
  localparam int SEL_W_DEF   = 3;
  localparam int CTX_IDX_W   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [CTX_IDX_W-1:0] ctx_inc(input logic [CTX_IDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/mux_ctx_regfile.sv
// Context storage: NUM_CTX select entries with one synchronous write port and
// one combinational read port. With MUX_CTX_SEQ_PARITY_EN defined a parity bit
// is stored next to every entry; otherwise the parity column does not exist and
// rpar_o reads 0.
//   clk, rst_n : clock, asynchronous active-low reset (clears all entries)
//   we_i       : write strobe
//   waddr_i    : entry written
//   wdata_i    : select value written
//   wpar_i     : parity bit written with wdata_i
//   raddr_i    : entry read
//   rdata_o    : stored select value of entry raddr_i
//   rpar_o     : stored parity bit of entry raddr_i
module mux_ctx_regfile
  import mux_ctx_sequencer_pkg::*;
#(
  parameter int NUM_CTX = NUM_CTX_DEF,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [CTX_IDX_W-1:0] waddr_i,
  input  logic [SEL_W-1:0]     wdata_i,
  input  logic                 wpar_i,
  input  logic [CTX_IDX_W-1:0] raddr_i,
  output logic [SEL_W-1:0]     rdata_o,
  output logic                 rpar_o
);

  logic [SEL_W-1:0] mem_q [NUM_CTX];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (int'(waddr_i) < NUM_CTX)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Indices beyond the populated depth read as zero rather than X.
  assign rdata_o = (int'(raddr_i) < NUM_CTX) ? mem_q[raddr_i] : '0;

`ifdef MUX_CTX_SEQ_PARITY_EN
  logic par_q [NUM_CTX];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        par_q[i] <= 1'b0;
      end
    end else if (we_i && (int'(waddr_i) < NUM_CTX)) begin
      par_q[waddr_i] <= wpar_i;
    end
  end

  assign rpar_o = (int'(raddr_i) < NUM_CTX) ? par_q[raddr_i] : 1'b0;
`else
  logic unused_wpar;
  assign unused_wpar = wpar_i;
  assign rpar_o      = 1'b0;
`endif

endmodule

// File: rtl/mux_ctx_sequencer.sv
// Context sequencer for a downstream 32b data mux. A table of select values is
// stepped through from context 0 up to a latched final context, optionally
// looping, with stall/stop control and a completion pulse.
// Optional feature macro: MUX_CTX_SEQ_PARITY_EN (per-entry even-parity check,
// sticky par_err). Without it par_err is tied low and cfg_par is ignored.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   cfg_we   : context write strobe (accepted in any state)
//   cfg_addr : context index written
//   cfg_data : select value written
//   cfg_par  : even-parity bit for cfg_data
//   start    : begin a run (IDLE only)
//   stop     : abort a run (highest priority)
//   stall    : hold the current context while running
//   ctx_last : final context index, latched at start
//   loop_en  : wrap to context 0 after the final context
//   select   : entry[ctx_idx], combinational
//   ctx_idx  : current context index
//   busy     : high while running
//   done     : one-cycle pulse after normal completion
//   par_err  : sticky parity error
module mux_ctx_sequencer
  import mux_ctx_sequencer_pkg::*;
#(
  parameter int NUM_CTX = NUM_CTX_DEF,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [CTX_IDX_W-1:0] cfg_addr,
  input  logic [SEL_W-1:0]     cfg_data,
  input  logic                 cfg_par,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 stall,
  input  logic [CTX_IDX_W-1:0] ctx_last,
  input  logic                 loop_en,
  output logic [SEL_W-1:0]     select,
  output logic [CTX_IDX_W-1:0] ctx_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 par_err
);

  state_e                 state_q, state_d;
  logic [CTX_IDX_W-1:0]   ctx_idx_q, ctx_idx_d;
  logic [CTX_IDX_W-1:0]   ctx_last_q, ctx_last_d;
  logic                   done_q, done_d;
  logic [SEL_W-1:0]       rd_data;
  logic                   rd_par;
  logic                   start_acc;

  mux_ctx_regfile #(
    .NUM_CTX (NUM_CTX),
    .SEL_W   (SEL_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_data),
    .wpar_i  (cfg_par),
    .raddr_i (ctx_idx_q),
    .rdata_o (rd_data),
    .rpar_o  (rd_par)
  );

  // A start is only taken in IDLE and loses to a simultaneous stop.
  assign start_acc = (state_q == ST_IDLE) && start && !stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ctx_idx_q  <= '0;
      ctx_last_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctx_idx_q  <= ctx_idx_d;
      ctx_last_q <= ctx_last_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctx_idx_d  = ctx_idx_q;
    ctx_last_d = ctx_last_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d    = ST_RUN;
          ctx_idx_d  = '0;
          ctx_last_d = ctx_last;
        end
      end
      ST_RUN: begin
        // stop > stall > advance/wrap/complete
        if (stop) begin
          state_d   = ST_IDLE;
          ctx_idx_d = '0;
        end else if (!stall) begin
          if (ctx_idx_q != ctx_last_q) begin
            ctx_idx_d = ctx_inc(ctx_idx_q);
          end else if (loop_en) begin
            ctx_idx_d = '0;
          end else begin
            state_d   = ST_IDLE;
            ctx_idx_d = '0;
            done_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        ctx_idx_d = '0;
      end
    endcase
  end

`ifdef MUX_CTX_SEQ_PARITY_EN
  logic par_err_q, par_err_d;

  function automatic logic parity_bad(input logic [SEL_W-1:0] data, input logic par);
    return (^data) ^ par;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  // Starts are accepted only in IDLE and errors are only raised in RUN, so
  // the clear and the set never collide.
  always_comb begin
    par_err_d = par_err_q;
    if (start_acc) begin
      par_err_d = 1'b0;
    end else if ((state_q == ST_RUN) && parity_bad(rd_data, rd_par)) begin
      par_err_d = 1'b1;
    end
  end

  assign par_err = par_err_q;
`else
  logic unused_rd_par;
  assign unused_rd_par = rd_par;
  assign par_err       = 1'b0;
`endif

  assign select  = rd_data;
  assign ctx_idx = ctx_idx_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = done_q;

endmodule
